// File: rtl/tt_um_ternary_mvm_if.sv
// Activation stream / result stream bundle for the ternary MVM stage.
// master = upstream driver (start, activations) and result consumer,
// slave  = the MVM stage itself.
interface tt_um_ternary_mvm_if;
  logic       ui_start;
  logic [7:0] ui_input;
  logic       ui_valid;
  logic [7:0] uo_output;
  logic       uo_valid;
  logic       uo_busy;

  modport master (
    output ui_start,
    output ui_input,
    output ui_valid,
    input  uo_output,
    input  uo_valid,
    input  uo_busy
  );

  modport slave (
    input  ui_start,
    input  ui_input,
    input  ui_valid,
    output uo_output,
    output uo_valid,
    output uo_busy
  );
endinterface

// File: rtl/tt_um_ternary_mvm.sv
// Ternary matrix-vector multiply stage.
// One pass: IDLE --start--> ACCUM (one activation row per valid beat)
// --last row--> DRAIN (one saturated column result per cycle) --> IDLE.
// Weights and the length parameter come straight from the weight loader
// and are read combinationally; the loader holds them stable for the pass.
module tt_um_ternary_mvm #(
  parameter int MAX_IN_LEN  = 16,
  parameter int MAX_OUT_LEN = 8
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 ena,
  input  logic [2*MAX_IN_LEN*MAX_OUT_LEN-1:0]  ui_weights,
  input  logic [6:0]                           ui_param,
  tt_um_ternary_mvm_if.slave                   bus
);

  // Counter widths follow the loader's parameter encoding: [6:3] rows, [2:0] cols.
  localparam int IN_W  = 4;
  localparam int OUT_W = 3;
  // 13 bits holds 16 x (+/-128) = +/-2048 without wrapping.
  localparam int ACC_W = 13;
  localparam int ROW_W = 2 * MAX_OUT_LEN;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ACCUM = 2'b01,
    S_DRAIN = 2'b10
  } state_t;

  state_t                   state_q;
  logic [IN_W-1:0]          in_cnt_q;
  logic [OUT_W-1:0]         out_cnt_q;
  logic signed [ACC_W-1:0]  acc_q [MAX_OUT_LEN];
  logic signed [ACC_W-1:0]  acc_d [MAX_OUT_LEN];
  logic [7:0]               uo_output_q;
  logic                     uo_valid_q;

  logic [IN_W-1:0]          in_last_s;
  logic [OUT_W-1:0]         out_last_s;
  logic [ROW_W-1:0]         row_s;
  logic signed [ACC_W-1:0]  act_ext_s;
  logic signed [ACC_W-1:0]  drain_sel_s;

  // Clamp an accumulator to the signed 8-bit output range.
  function automatic logic [7:0] sat8(input logic signed [ACC_W-1:0] v);
    logic [7:0] r;
    if (v > 13'sd127) begin
      r = 8'h7F;
    end else if (v < -13'sd128) begin
      r = 8'h80;
    end else begin
      r = v[7:0];
    end
    return r;
  endfunction

  // Apply one ternary weight to an accumulator: 01 adds, 11 subtracts,
  // 00 and the unused code 10 leave it alone.
  function automatic logic signed [ACC_W-1:0] tern_mac(
    input logic [1:0]              code,
    input logic signed [ACC_W-1:0] acc,
    input logic signed [ACC_W-1:0] act
  );
    logic signed [ACC_W-1:0] r;
    case (code)
      2'b01:   r = acc + act;
      2'b11:   r = acc - act;
      default: r = acc;
    endcase
    return r;
  endfunction

  assign in_last_s  = ui_param[6:3];
  assign out_last_s = ui_param[2:0];

  // Select the weight row addressed by the current activation index.
  always_comb begin
    row_s = ui_weights[int'(in_cnt_q) * ROW_W +: ROW_W];
  end

  // Sign-extend the incoming activation to accumulator width.
  always_comb begin
    act_ext_s = {{(ACC_W-8){bus.ui_input[7]}}, bus.ui_input};
  end

  // Next accumulator values for an accepted activation; inactive columns hold.
  always_comb begin
    for (int j = 0; j < MAX_OUT_LEN; j++) begin
      if (OUT_W'(j) <= out_last_s) begin
        acc_d[j] = tern_mac(row_s[2*j +: 2], acc_q[j], act_ext_s);
      end else begin
        acc_d[j] = acc_q[j];
      end
    end
  end

  // Accumulator addressed by the drain counter.
  always_comb begin
    drain_sel_s = acc_q[out_cnt_q];
  end

  // Pass sequencer: state, counters, accumulators and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      uo_output_q <= 8'h00;
      uo_valid_q  <= 1'b0;
      for (int j = 0; j < MAX_OUT_LEN; j++) begin
        acc_q[j] <= '0;
      end
    end else if (!ena) begin
      // Frozen: everything holds except that no result is presented.
      uo_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          uo_valid_q <= 1'b0;
          if (bus.ui_start) begin
            for (int j = 0; j < MAX_OUT_LEN; j++) begin
              acc_q[j] <= '0;
            end
            in_cnt_q <= '0;
            state_q  <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          uo_valid_q <= 1'b0;
          if (bus.ui_valid) begin
            for (int j = 0; j < MAX_OUT_LEN; j++) begin
              acc_q[j] <= acc_d[j];
            end
            if (in_cnt_q == in_last_s) begin
              out_cnt_q <= '0;
              state_q   <= S_DRAIN;
            end else begin
              in_cnt_q <= in_cnt_q + 4'd1;
            end
          end
        end
        S_DRAIN: begin
          uo_output_q <= sat8(drain_sel_s);
          uo_valid_q  <= 1'b1;
          if (out_cnt_q == out_last_s) begin
            state_q <= S_IDLE;
          end else begin
            out_cnt_q <= out_cnt_q + 3'd1;
          end
        end
        default: begin
          uo_valid_q <= 1'b0;
          state_q    <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.uo_output = uo_output_q;
  assign bus.uo_valid  = uo_valid_q;
  assign bus.uo_busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_tt_um_ternary_mvm.sv
// Self-checking bench for tt_um_ternary_mvm: directed cases plus random
// passes compared against a plain-arithmetic dot-product model.
module tb_tt_um_ternary_mvm;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ena;
  logic [255:0] ui_weights;
  logic [6:0]   ui_param;

  tt_um_ternary_mvm_if bus ();

  tt_um_ternary_mvm dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .ui_weights (ui_weights),
    .ui_param   (ui_param),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  int code [16][8];   // 2-bit weight codes, row i, column j
  int xin  [16];      // activations
  int expv [8];       // expected results

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int tern(input int c);
    if (c == 1) return 1;
    if (c == 3) return -1;
    return 0;
  endfunction

  task automatic model(input int in_len, input int out_len);
    for (int j = 0; j < out_len; j++) begin
      int s = 0;
      for (int i = 0; i < in_len; i++) s += tern(code[i][j]) * xin[i];
      if (s > 127) s = 127;
      if (s < -128) s = -128;
      expv[j] = s;
    end
  endtask

  task automatic pack_weights();
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 8; j++)
        ui_weights[2*(i*8+j) +: 2] = 2'(code[i][j]);
  endtask

  task automatic fill_codes(input int c);
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 8; j++) code[i][j] = c;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full pass. stall: idle beat before every activation.
  // gap_at: drain index before which ena drops for 3 cycles (-1 = none).
  // pulses: ui_start asserted during ACCUM/DRAIN and junk ui_valid in DRAIN.
  task automatic run_pass(input int in_len, input int out_len, input bit stall,
                          input int gap_at, input bit pulses, input string tag);
    ui_param = {4'(in_len - 1), 3'(out_len - 1)};
    pack_weights();
    model(in_len, out_len);
    // start cycle carries a valid activation that must be ignored
    bus.ui_start = 1'b1;
    bus.ui_valid = 1'b1;
    bus.ui_input = 8'($urandom_range(1, 127));
    tick();
    bus.ui_start = 1'b0;
    check({tag, "/busy_after_start"}, 32'(bus.uo_busy), 1);
    for (int k = 0; k < in_len; k++) begin
      if (stall) begin
        bus.ui_valid = 1'b0;
        bus.ui_input = 8'($urandom);
        bus.ui_start = pulses;
        tick();
      end
      bus.ui_start = pulses;
      bus.ui_valid = 1'b1;
      bus.ui_input = 8'(xin[k]);
      tick();
    end
    bus.ui_valid = 1'b0;
    bus.ui_start = 1'b0;
    check({tag, "/valid_at_EN"}, 32'(bus.uo_valid), 0);
    check({tag, "/busy_at_EN"}, 32'(bus.uo_busy), 1);
    for (int idx = 0; idx < out_len; idx++) begin
      if (idx == gap_at) begin
        ena = 1'b0;
        repeat (3) begin
          tick();
          check({tag, "/valid_in_gap"}, 32'(bus.uo_valid), 0);
          if (idx > 0) check({tag, "/hold_in_gap"}, $signed(bus.uo_output), expv[idx-1]);
        end
        ena = 1'b1;
      end
      bus.ui_start = pulses;
      bus.ui_valid = pulses;
      bus.ui_input = 8'($urandom);
      tick();
      bus.ui_start = 1'b0;
      bus.ui_valid = 1'b0;
      check($sformatf("%s/valid[%0d]", tag, idx), 32'(bus.uo_valid), 1);
      check($sformatf("%s/out[%0d]", tag, idx), $signed(bus.uo_output), expv[idx]);
    end
    check({tag, "/busy_end"}, 32'(bus.uo_busy), 0);
    tick();
    check({tag, "/valid_after_end"}, 32'(bus.uo_valid), 0);
  endtask

  initial begin
    rst_n        = 1'b0;
    ena          = 1'b1;
    ui_weights   = '0;
    ui_param     = 7'd0;
    bus.ui_start = 1'b0;
    bus.ui_valid = 1'b0;
    bus.ui_input = 8'd0;
    repeat (2) tick();
    rst_n = 1'b1;
    check("reset/out", $signed(bus.uo_output), 0);
    check("reset/valid", 32'(bus.uo_valid), 0);
    check("reset/busy", 32'(bus.uo_busy), 0);

    // all +1, 10..40, two columns
    fill_codes(1);
    for (int k = 0; k < 16; k++) xin[k] = 10 * (k + 1);
    run_pass(4, 2, 1'b0, -1, 1'b0, "plus");

    // column codes +1, -1, illegal
    for (int i = 0; i < 16; i++) begin
      code[i][0] = 1; code[i][1] = 3; code[i][2] = 2;
    end
    run_pass(4, 3, 1'b0, -1, 1'b0, "mixed");
    // stalled input plus ena gap mid-drain
    run_pass(4, 3, 1'b1, 1, 1'b0, "stall_gap");
    // stray starts and valids outside their states
    run_pass(4, 3, 1'b0, -1, 1'b1, "pulses");

    // saturation
    fill_codes(1);
    for (int k = 0; k < 16; k++) xin[k] = 127;
    run_pass(16, 1, 1'b0, -1, 1'b0, "sat_hi");
    for (int k = 0; k < 16; k++) xin[k] = -128;
    run_pass(16, 1, 1'b0, -1, 1'b0, "sat_lo");
    fill_codes(3);
    run_pass(16, 1, 1'b0, -1, 1'b0, "sat_neg");

    // reset mid-pass
    fill_codes(1);
    for (int k = 0; k < 16; k++) xin[k] = 10 * (k + 1);
    ui_param = {4'd3, 3'd1};
    pack_weights();
    bus.ui_start = 1'b1;
    tick();
    bus.ui_start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      bus.ui_valid = 1'b1;
      bus.ui_input = 8'(xin[k]);
      tick();
    end
    bus.ui_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst/out", $signed(bus.uo_output), 0);
    check("midrst/valid", 32'(bus.uo_valid), 0);
    check("midrst/busy", 32'(bus.uo_busy), 0);
    tick();
    check("midrst/valid_later", 32'(bus.uo_valid), 0);
    run_pass(4, 2, 1'b0, -1, 1'b0, "after_rst");

    // random passes
    for (int t = 0; t < 30; t++) begin
      int il, ol, gap;
      il = $urandom_range(1, 16);
      ol = $urandom_range(1, 8);
      for (int i = 0; i < 16; i++)
        for (int j = 0; j < 8; j++) code[i][j] = $urandom_range(0, 3);
      for (int k = 0; k < 16; k++) xin[k] = $urandom_range(0, 255) - 128;
      gap = $urandom_range(0, ol);
      if (gap == ol) gap = -1;
      run_pass(il, ol, 1'($urandom_range(0, 1)), gap, 1'($urandom_range(0, 1)),
               $sformatf("rnd%0d", t));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
